// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel tick, active-low syncs, video_on and pixel coordinates.
// Define VGA_TIMING_FRAME_CNT_EN to build the 8-bit frame counter behind frame_cnt.
module vga_timing_gen #(
    parameter int unsigned TICK_DIV  = 2,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    generate
        if (TICK_DIV > 1) begin : g_div
            localparam int unsigned DIV_W = $clog2(TICK_DIV);
            logic [DIV_W-1:0] div_cnt_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    div_cnt_q <= '0;
                end else if (p_tick) begin
                    div_cnt_q <= '0;
                end else begin
                    div_cnt_q <= div_cnt_q + 1'b1;
                end
            end

            assign p_tick = (div_cnt_q == DIV_W'(TICK_DIV - 1));
        end else begin : g_nodiv
            assign p_tick = 1'b1;
        end
    endgenerate

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (p_tick) begin
            if (h_cnt_q == 10'(H_TOTAL - 1)) begin
                h_cnt_d = '0;
                if (v_cnt_q == 10'(V_TOTAL - 1)) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Syncs decode the next-state counts so they stay aligned with pixel_x/pixel_y.
    always_comb begin
        hsync_d = !((h_cnt_d >= 10'(HS_START)) && (h_cnt_d <= 10'(HS_END)));
        vsync_d = !((v_cnt_d >= 10'(VS_START)) && (v_cnt_d <= 10'(VS_END)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign video_on    = (h_cnt_q < 10'(H_DISPLAY)) && (v_cnt_q < 10'(V_DISPLAY));
    assign frame_start = p_tick && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule
